// File: rtl/sata_oob_ctrl_if.sv
// Signal bundle between the SATA OOB sequencer and the GTH wrapper / link layer.
// The master modport is the sequencer's view; the slave modport is the GTH/link side.
interface sata_oob_ctrl_if;
    logic        tx_reset_done;
    logic        rx_reset_done;
    logic        rx_cominit_det;
    logic        rx_comwake_det;
    logic        RXELECIDLE0;
    logic [31:0] RXDATA;
    logic [3:0]  RXCHARISK0;
    logic        RXBYTEISALIGNED0;
    logic [31:0] user_txdata;
    logic        user_txcharisk;
    logic        tx_cominit;
    logic        tx_comwake;
    logic        TXELECIDLE;
    logic [31:0] TXDATA;
    logic        TXCHARISK;
    logic        rx_start;
    logic        link_up;
    logic [3:0]  oob_state;

    modport master (
        input  tx_reset_done, rx_reset_done, rx_cominit_det, rx_comwake_det,
               RXELECIDLE0, RXDATA, RXCHARISK0, RXBYTEISALIGNED0,
               user_txdata, user_txcharisk,
        output tx_cominit, tx_comwake, TXELECIDLE, TXDATA, TXCHARISK,
               rx_start, link_up, oob_state
    );

    modport slave (
        output tx_reset_done, rx_reset_done, rx_cominit_det, rx_comwake_det,
               RXELECIDLE0, RXDATA, RXCHARISK0, RXBYTEISALIGNED0,
               user_txdata, user_txcharisk,
        input  tx_cominit, tx_comwake, TXELECIDLE, TXDATA, TXCHARISK,
               rx_start, link_up, oob_state
    );
endinterface

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB / link-init sequencer: COMRESET/COMWAKE, D10.2/ALIGN handshake, then link-layer TX.
// Optional SATA_OOB_IDLE_LINKDOWN_EN: 16 consecutive RX electrical-idle cycles in LINK_UP force a COMRESET.
module sata_oob_ctrl #(
    parameter int unsigned RETRY_CYCLES  = 1500000,
    parameter int unsigned ALIGN_TIMEOUT = 131072,
    parameter int unsigned NONALIGN_CNT  = 3
) (
    input  logic            logic_clk,
    input  logic            gth_reset,
    sata_oob_ctrl_if.master bus
);
    localparam logic [31:0] ALIGN_PRIM  = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_KMASK = 4'b0001;
    localparam logic [31:0] D102_PRIM   = 32'h4A4A4A4A;

    localparam int unsigned TIMER_MAX = (RETRY_CYCLES > ALIGN_TIMEOUT) ? RETRY_CYCLES : ALIGN_TIMEOUT;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int unsigned CNT_W     = $clog2(NONALIGN_CNT + 1);

    localparam logic [TIMER_W-1:0] RETRY_LAST   = TIMER_W'(RETRY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ALIGN_LAST   = TIMER_W'(ALIGN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_SAT    = {TIMER_W{1'b1}};
    localparam logic [CNT_W-1:0]   NONALIGN_TGT = CNT_W'(NONALIGN_CNT);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_COMRESET     = 4'd1,
        ST_WAIT_COMINIT = 4'd2,
        ST_COMWAKE      = 4'd3,
        ST_WAIT_COMWAKE = 4'd4,
        ST_WAIT_NOIDLE  = 4'd5,
        ST_SEND_D102    = 4'd6,
        ST_SEND_ALIGN   = 4'd7,
        ST_LINK_UP      = 4'd8
    } oob_state_t;

    oob_state_t         state_r;
    oob_state_t         state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [CNT_W-1:0]   nonalign_r;
    logic [CNT_W-1:0]   nonalign_s;

    logic resets_done_s;
    logic post_cominit_s;
    logic align_rx_s;
    logic nonalign_word_s;
    logic retry_expired_s;
    logic align_expired_s;
    logic idle_hit_s;

    logic        tx_cominit_s, tx_comwake_s, txelecidle_s, txcharisk_s, rx_start_s, link_up_s;
    logic [31:0] txdata_s;
    logic        tx_cominit_r, tx_comwake_r, txelecidle_r, txcharisk_r, rx_start_r, link_up_r;
    logic [31:0] txdata_r;
    logic [3:0]  oob_state_r;

    assign resets_done_s   = bus.tx_reset_done & bus.rx_reset_done;
    // States from COMWAKE onward abandon the handshake when the device re-issues COMINIT
    assign post_cominit_s  = (state_r != ST_IDLE) && (state_r != ST_COMRESET) &&
                             (state_r != ST_WAIT_COMINIT);
    assign align_rx_s      = (bus.RXDATA == ALIGN_PRIM) && (bus.RXCHARISK0 == ALIGN_KMASK) &&
                             bus.RXBYTEISALIGNED0;
    assign nonalign_word_s = bus.RXCHARISK0[0] && (bus.RXDATA != ALIGN_PRIM);
    assign retry_expired_s = (timer_r == RETRY_LAST);
    assign align_expired_s = (timer_r == ALIGN_LAST);

    // Run length of consecutive non-ALIGN primitives seen while sending ALIGN
    always_comb begin
        nonalign_s = {CNT_W{1'b0}};
        if ((state_r == ST_SEND_ALIGN) && nonalign_word_s) begin
            nonalign_s = nonalign_r + CNT_W'(1'b1);
        end else begin
            nonalign_s = {CNT_W{1'b0}};
        end
    end

`ifdef SATA_OOB_IDLE_LINKDOWN_EN
    localparam logic [4:0] IDLE_LIMIT = 5'd16;
    logic [4:0] idle_r;
    logic [4:0] idle_s;

    // Run length of RX electrical idle while the link is up
    always_comb begin
        idle_s = 5'd0;
        if ((state_r == ST_LINK_UP) && bus.RXELECIDLE0) begin
            idle_s = idle_r + 5'd1;
        end else begin
            idle_s = 5'd0;
        end
    end

    assign idle_hit_s = (idle_s == IDLE_LIMIT);

    // Idle run-length register
    always_ff @(posedge logic_clk) begin
        if (gth_reset) begin
            idle_r <= 5'd0;
        end else if (state_s != state_r) begin
            idle_r <= 5'd0;
        end else begin
            idle_r <= idle_s;
        end
    end
`else
    assign idle_hit_s = 1'b0;
`endif

    // Next-state logic; detect events are tested ahead of timeouts
    always_comb begin
        state_s = state_r;
        if (!resets_done_s) begin
            state_s = ST_IDLE;
        end else if (bus.rx_cominit_det && post_cominit_s) begin
            state_s = ST_COMRESET;
        end else begin
            case (state_r)
                ST_IDLE:         state_s = ST_COMRESET;
                ST_COMRESET:     state_s = ST_WAIT_COMINIT;
                ST_WAIT_COMINIT: begin
                    if (bus.rx_cominit_det)   state_s = ST_COMWAKE;
                    else if (retry_expired_s) state_s = ST_COMRESET;
                    else                      state_s = ST_WAIT_COMINIT;
                end
                ST_COMWAKE:      state_s = ST_WAIT_COMWAKE;
                ST_WAIT_COMWAKE: begin
                    if (bus.rx_comwake_det)   state_s = ST_WAIT_NOIDLE;
                    else if (retry_expired_s) state_s = ST_COMRESET;
                    else                      state_s = ST_WAIT_COMWAKE;
                end
                ST_WAIT_NOIDLE: begin
                    if (!bus.RXELECIDLE0) state_s = ST_SEND_D102;
                    else                  state_s = ST_WAIT_NOIDLE;
                end
                ST_SEND_D102: begin
                    if (align_rx_s)           state_s = ST_SEND_ALIGN;
                    else if (align_expired_s) state_s = ST_COMRESET;
                    else                      state_s = ST_SEND_D102;
                end
                ST_SEND_ALIGN: begin
                    if (nonalign_s == NONALIGN_TGT) state_s = ST_LINK_UP;
                    else if (align_expired_s)       state_s = ST_COMRESET;
                    else                            state_s = ST_SEND_ALIGN;
                end
                ST_LINK_UP: begin
                    if (idle_hit_s) state_s = ST_COMRESET;
                    else            state_s = ST_LINK_UP;
                end
                default:         state_s = ST_IDLE;
            endcase
        end
    end

    // State register, dwell timer (cleared on change, saturating) and non-ALIGN run counter
    always_ff @(posedge logic_clk) begin
        if (gth_reset) begin
            state_r    <= ST_IDLE;
            timer_r    <= {TIMER_W{1'b0}};
            nonalign_r <= {CNT_W{1'b0}};
        end else if (state_s != state_r) begin
            state_r    <= state_s;
            timer_r    <= {TIMER_W{1'b0}};
            nonalign_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_r;
            timer_r    <= (timer_r == TIMER_SAT) ? timer_r : timer_r + TIMER_W'(1'b1);
            nonalign_r <= nonalign_s;
        end
    end

    // Output decode from the current state; registered below so outputs trail the state by one cycle
    always_comb begin
        tx_cominit_s = 1'b0;
        tx_comwake_s = 1'b0;
        txelecidle_s = 1'b1;
        txdata_s     = 32'h0000_0000;
        txcharisk_s  = 1'b0;
        rx_start_s   = 1'b0;
        link_up_s    = 1'b0;
        case (state_r)
            ST_COMRESET: tx_cominit_s = 1'b1;
            ST_COMWAKE:  tx_comwake_s = 1'b1;
            ST_SEND_D102: begin
                txelecidle_s = 1'b0;
                txdata_s     = D102_PRIM;
            end
            ST_SEND_ALIGN: begin
                txelecidle_s = 1'b0;
                txdata_s     = ALIGN_PRIM;
                txcharisk_s  = ALIGN_KMASK[0];
                rx_start_s   = 1'b1;
            end
            ST_LINK_UP: begin
                txelecidle_s = 1'b0;
                txdata_s     = bus.user_txdata;
                txcharisk_s  = bus.user_txcharisk;
                rx_start_s   = 1'b1;
                link_up_s    = 1'b1;
            end
            default:     txelecidle_s = 1'b1;
        endcase
    end

    // Output registers
    always_ff @(posedge logic_clk) begin
        if (gth_reset) begin
            tx_cominit_r <= 1'b0;
            tx_comwake_r <= 1'b0;
            txelecidle_r <= 1'b1;
            txdata_r     <= 32'h0000_0000;
            txcharisk_r  <= 1'b0;
            rx_start_r   <= 1'b0;
            link_up_r    <= 1'b0;
            oob_state_r  <= 4'd0;
        end else begin
            tx_cominit_r <= tx_cominit_s;
            tx_comwake_r <= tx_comwake_s;
            txelecidle_r <= txelecidle_s;
            txdata_r     <= txdata_s;
            txcharisk_r  <= txcharisk_s;
            rx_start_r   <= rx_start_s;
            link_up_r    <= link_up_s;
            oob_state_r  <= state_r;
        end
    end

    assign bus.tx_cominit = tx_cominit_r;
    assign bus.tx_comwake = tx_comwake_r;
    assign bus.TXELECIDLE = txelecidle_r;
    assign bus.TXDATA     = txdata_r;
    assign bus.TXCHARISK  = txcharisk_r;
    assign bus.rx_start   = rx_start_r;
    assign bus.link_up    = link_up_r;
    assign bus.oob_state  = oob_state_r;
endmodule
